// File: rtl/seq_pkg.sv
// Shared types and widths for the hex adder operand sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_ENTER_A = 2'b00,
        ST_ENTER_B = 2'b01,
        ST_CALC    = 2'b10,
        ST_SHOW    = 2'b11
    } seq_state_t;

    localparam int DEFAULT_DIGITS = 3;
    localparam int SEQ_W          = 4 * DEFAULT_DIGITS;
    localparam int SEQ_SUM_W      = SEQ_W + 1;

endpackage

// File: rtl/module_digit_shift_reg.sv
// Nibble shift register with a saturating digit counter for one operand.
// clr together with shift restarts the operand with din[3:0] as its only digit.
module module_digit_shift_reg
    import seq_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int CNT_W  = 2,
    localparam int W     = 4 * DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clr,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     q,
    output logic [CNT_W-1:0] cnt
);

    logic [W-1:0]     q_q;
    logic [CNT_W-1:0] cnt_q;

    // Operand value and digit count; load takes a whole word and counts as zero digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            q_q   <= din;
            cnt_q <= '0;
        end else if (clr) begin
            if (shift) begin
                q_q   <= {{(W-4){1'b0}}, din[3:0]};
                cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                q_q   <= '0;
                cnt_q <= '0;
            end
        end else if (shift && (cnt_q < CNT_W'(DIGITS))) begin
            q_q   <= {q_q[W-5:0], din[3:0]};
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            q_q   <= q_q;
            cnt_q <= cnt_q;
        end
    end

    assign q   = q_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/module_operand_sequencer.sv
// Operand entry / start-done handshake / result latch for the 12-bit hex adder.
// Optional SEQ_AUTO_ENTER_EN: the last digit of an operand implies enter.
module module_operand_sequencer
    import seq_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int CNT_W  = 2,
    localparam int W     = 4 * DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic             enter,
    input  logic             clear,
    input  logic             calc_done,
    input  logic [W:0]       sum_in,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    output logic             calc_start,
    output logic [W:0]       result,
    output logic             result_valid,
    output logic [W:0]       display_value,
    output logic [CNT_W-1:0] digit_cnt,
    output logic [1:0]       state
);

    seq_state_t       state_q, state_d;
    logic [W:0]       result_q, result_d;
    logic             rv_q, rv_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] digit_cnt_q, digit_cnt_d;

    logic             a_load_s, a_shift_s, a_clr_s, b_shift_s, b_clr_s;
    logic [W-1:0]     a_din_s, b_din_s;
    logic [CNT_W-1:0] cnt_a_s, cnt_b_s, cur_cnt_s, cnt_inc_s;
    logic             digit_accept_s;

    module_digit_shift_reg #(.DIGITS(DIGITS), .CNT_W(CNT_W)) u_op_a (
        .clk(clk), .rst(rst), .load(a_load_s), .shift(a_shift_s), .clr(a_clr_s),
        .din(a_din_s), .q(op_a), .cnt(cnt_a_s)
    );

    module_digit_shift_reg #(.DIGITS(DIGITS), .CNT_W(CNT_W)) u_op_b (
        .clk(clk), .rst(rst), .load(1'b0), .shift(b_shift_s), .clr(b_clr_s),
        .din(b_din_s), .q(op_b), .cnt(cnt_b_s)
    );

    assign cur_cnt_s      = (state_q == ST_ENTER_A) ? cnt_a_s : cnt_b_s;
    assign cnt_inc_s      = cur_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1};
    assign digit_accept_s = digit_valid && (cur_cnt_s < CNT_W'(DIGITS));
    assign b_din_s        = {{(W-4){1'b0}}, digit};

`ifdef SEQ_AUTO_ENTER_EN
    logic last_digit_s;
    assign last_digit_s = (cur_cnt_s == CNT_W'(DIGITS - 1));
`endif

    // Next-state decode; priority is clear > enter > digit_valid.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        rv_d        = rv_q;
        start_d     = 1'b0;
        digit_cnt_d = digit_cnt_q;
        a_load_s    = 1'b0;
        a_shift_s   = 1'b0;
        a_clr_s     = 1'b0;
        b_shift_s   = 1'b0;
        b_clr_s     = 1'b0;
        a_din_s     = {{(W-4){1'b0}}, digit};
        if (clear) begin
            a_clr_s     = 1'b1;
            b_clr_s     = 1'b1;
            state_d     = ST_ENTER_A;
            result_d    = '0;
            rv_d        = 1'b0;
            digit_cnt_d = '0;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (enter) begin
                        b_clr_s     = 1'b1;
                        state_d     = ST_ENTER_B;
                        digit_cnt_d = '0;
                    end else if (digit_accept_s) begin
                        a_shift_s   = 1'b1;
                        digit_cnt_d = cnt_inc_s;
`ifdef SEQ_AUTO_ENTER_EN
                        if (last_digit_s) begin
                            b_clr_s     = 1'b1;
                            state_d     = ST_ENTER_B;
                            digit_cnt_d = '0;
                        end else begin
                            b_clr_s     = 1'b0;
                        end
`endif
                    end else begin
                        a_shift_s = 1'b0;
                    end
                end
                ST_ENTER_B: begin
                    if (enter) begin
                        state_d = ST_CALC;
                        start_d = 1'b1;
                    end else if (digit_accept_s) begin
                        b_shift_s   = 1'b1;
                        digit_cnt_d = cnt_inc_s;
`ifdef SEQ_AUTO_ENTER_EN
                        if (last_digit_s) begin
                            state_d = ST_CALC;
                            start_d = 1'b1;
                        end else begin
                            start_d = 1'b0;
                        end
`endif
                    end else begin
                        b_shift_s = 1'b0;
                    end
                end
                ST_CALC: begin
                    if (calc_done) begin
                        result_d = sum_in;
                        rv_d     = 1'b1;
                        state_d  = ST_SHOW;
                    end else begin
                        rv_d     = rv_q;
                    end
                end
                ST_SHOW: begin
                    if (enter) begin
                        // Chain: the carry bit is dropped when the sum becomes operand A.
                        a_load_s    = 1'b1;
                        a_din_s     = result_q[W-1:0];
                        b_clr_s     = 1'b1;
                        digit_cnt_d = '0;
                        rv_d        = 1'b0;
                        state_d     = ST_ENTER_B;
                    end else if (digit_valid) begin
                        a_clr_s     = 1'b1;
                        a_shift_s   = 1'b1;
                        b_clr_s     = 1'b1;
                        digit_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                        rv_d        = 1'b0;
                        state_d     = ST_ENTER_A;
                    end else begin
                        rv_d        = rv_q;
                    end
                end
                default: begin
                    state_d = ST_ENTER_A;
                end
            endcase
        end
    end

    // Control registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ENTER_A;
            result_q    <= '0;
            rv_q        <= 1'b0;
            start_q     <= 1'b0;
            digit_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            rv_q        <= rv_d;
            start_q     <= start_d;
            digit_cnt_q <= digit_cnt_d;
        end
    end

    // Display source follows the operand currently being edited or the latched sum.
    always_comb begin
        display_value = {1'b0, op_a};
        case (state_q)
            ST_ENTER_A: display_value = {1'b0, op_a};
            ST_ENTER_B: display_value = {1'b0, op_b};
            ST_CALC:    display_value = {1'b0, op_b};
            ST_SHOW:    display_value = result_q;
            default:    display_value = {1'b0, op_a};
        endcase
    end

    assign calc_start   = start_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign digit_cnt    = digit_cnt_q;
    assign state        = state_q;

endmodule

// File: tb/tb_module_operand_sequencer.sv
// Directed scenarios plus random stimulus checked against a behavioural model.
module tb_module_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst, digit_valid, enter, clear, calc_done;
    logic [3:0]  digit;
    logic [12:0] sum_in;
    logic [11:0] op_a, op_b;
    logic        calc_start, result_valid;
    logic [12:0] result, display_value;
    logic [1:0]  digit_cnt, state;

    int errors = 0;
    int checks = 0;

    int m_state, m_a, m_b, m_res, m_rv, m_cnt, m_start;

`ifdef SEQ_AUTO_ENTER_EN
    localparam bit AUTO = 1'b1;
    localparam logic [31:0] T2_STATE = 32'd1;
    localparam logic [31:0] T2_OPB   = 32'h00D;
    localparam logic [31:0] T2_CNT   = 32'd1;
`else
    localparam bit AUTO = 1'b0;
    localparam logic [31:0] T2_STATE = 32'd0;
    localparam logic [31:0] T2_OPB   = 32'h000;
    localparam logic [31:0] T2_CNT   = 32'd3;
`endif

    always #5 clk = ~clk;

    module_operand_sequencer #(.DIGITS(3), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .enter(enter), .clear(clear), .calc_done(calc_done), .sum_in(sum_in),
        .op_a(op_a), .op_b(op_b), .calc_start(calc_start), .result(result),
        .result_valid(result_valid), .display_value(display_value),
        .digit_cnt(digit_cnt), .state(state)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Calculator rules: 0=enter A, 1=enter B, 2=calc, 3=show.
    task automatic model_step(input bit r, input bit c, input bit e, input bit dv,
                              input int dg, input bit dn, input int sm);
        int nstart;
        nstart = 0;
        if (r || c) begin
            m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_rv = 0; m_cnt = 0;
        end else if (m_state == 0) begin
            if (e) begin
                m_state = 1; m_b = 0; m_cnt = 0;
            end else if (dv && m_cnt < 3) begin
                m_a = (m_a * 16 + dg) % 4096; m_cnt++;
                if (AUTO && m_cnt == 3) begin m_state = 1; m_b = 0; m_cnt = 0; end
            end
        end else if (m_state == 1) begin
            if (e) begin
                m_state = 2; nstart = 1;
            end else if (dv && m_cnt < 3) begin
                m_b = (m_b * 16 + dg) % 4096; m_cnt++;
                if (AUTO && m_cnt == 3) begin m_state = 2; nstart = 1; end
            end
        end else if (m_state == 2) begin
            if (dn) begin m_res = sm % 8192; m_rv = 1; m_state = 3; end
        end else begin
            if (e) begin
                m_a = m_res % 4096; m_b = 0; m_cnt = 0; m_rv = 0; m_state = 1;
            end else if (dv) begin
                m_a = dg; m_b = 0; m_cnt = 1; m_rv = 0; m_state = 0;
            end
        end
        m_start = nstart;
    endtask

    task automatic check_all();
        int disp;
        disp = (m_state == 0) ? m_a : (m_state == 3) ? m_res : m_b;
        check_val("state", 32'(state), 32'(m_state));
        check_val("op_a", 32'(op_a), 32'(m_a));
        check_val("op_b", 32'(op_b), 32'(m_b));
        check_val("result", 32'(result), 32'(m_res));
        check_val("result_valid", 32'(result_valid), 32'(m_rv));
        check_val("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
        check_val("calc_start", 32'(calc_start), 32'(m_start));
        check_val("display_value", 32'(display_value), 32'(disp));
    endtask

    task automatic cyc(input bit r, input bit c, input bit e, input bit dv,
                       input int dg, input bit dn, input int sm);
        logic [31:0] sv;
        sv          = sm;
        rst         = r;
        clear       = c;
        enter       = e;
        digit_valid = dv;
        digit       = 4'(dg);
        calc_done   = dn;
        sum_in      = sv[12:0];
        @(posedge clk);
        model_step(r, c, e, dv, dg, dn, 32'(sv[12:0]));
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic reset_cyc();       cyc(1, 0, 0, 0, 0, 0, 0);               endtask
    task automatic dig(input int d);  cyc(0, 0, 0, 1, d, 0, 0);               endtask
    task automatic ent();             cyc(0, 0, 1, 0, 0, 0, 0);               endtask
    task automatic idle();            cyc(0, 0, 0, 0, 0, 0, 0);               endtask
    task automatic done_ok();         cyc(0, 0, 0, 0, 0, 1, m_a + m_b);       endtask
    task automatic ent_manual();      if (!AUTO) ent();                       endtask

    initial begin
        rst = 1'b0; clear = 1'b0; enter = 1'b0; digit_valid = 1'b0;
        digit = 4'h0; calc_done = 1'b0; sum_in = 13'h0;
        m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_rv = 0; m_cnt = 0; m_start = 0;
        @(negedge clk);

        // 1: basic add, done two cycles after start
        reset_cyc();
        check_val("t1_reset_state", 32'(state), 32'd0);
        dig(1); dig(2); dig(3); ent_manual();
        dig(15); dig(15); dig(15); ent_manual();
        check_val("t1_start", 32'(calc_start), 32'd1);
        idle(); idle(); done_ok();
        check_val("t1_op_a", 32'(op_a), 32'h123);
        check_val("t1_op_b", 32'(op_b), 32'hFFF);
        check_val("t1_result", 32'(result), 32'h1122);
        check_val("t1_state", 32'(state), 32'd3);

        // 2: fourth digit in enter A
        reset_cyc();
        dig(10); dig(11); dig(12); dig(13);
        check_val("t2_op_a", 32'(op_a), 32'hABC);
        check_val("t2_state", 32'(state), T2_STATE);
        check_val("t2_op_b", 32'(op_b), T2_OPB);
        check_val("t2_cnt", 32'(digit_cnt), T2_CNT);

        // 3: chain result with carry dropped
        reset_cyc();
        dig(15); dig(15); dig(15); ent_manual();
        dig(15); dig(15); dig(15); ent_manual();
        done_ok();
        check_val("t3_first", 32'(result), 32'h1FFE);
        ent(); dig(0); dig(0); dig(2); ent_manual();
        done_ok();
        check_val("t3_op_a", 32'(op_a), 32'hFFE);
        check_val("t3_op_b", 32'(op_b), 32'h002);
        check_val("t3_result", 32'(result), 32'h1000);

        // 4: clear beats digit; stray calc_done ignored
        reset_cyc();
        dig(5); ent(); dig(7);
        cyc(0, 1, 0, 1, 9, 0, 0);
        check_val("t4_op_a", 32'(op_a), 32'h0);
        check_val("t4_state", 32'(state), 32'd0);
        cyc(0, 0, 0, 0, 0, 1, 13'h1234);
        check_val("t4_result", 32'(result), 32'h0);

        // 5: reset during calc drops the pending done
        reset_cyc();
        dig(1); ent(); dig(2); ent();
        reset_cyc();
        cyc(0, 0, 0, 0, 0, 1, 3);
        check_val("t5_state", 32'(state), 32'd0);
        check_val("t5_rv", 32'(result_valid), 32'd0);

        // 6: done together with calc_start
        reset_cyc();
        dig(4); ent(); dig(5); ent();
        done_ok();
        check_val("t6_state", 32'(state), 32'd3);
        check_val("t6_result", 32'(result), 32'h9);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, c, e, dv, dn;
            int sm;
            r  = ($urandom_range(0, 99) == 0);
            c  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 5) == 0);
            dv = ($urandom_range(0, 1) == 0);
            dn = ($urandom_range(0, 2) == 0);
            sm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191)) : m_a + m_b;
            cyc(r, c, e, dv, int'($urandom_range(0, 15)), dn, sm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
